// File: rtl/ascii_uart_tx.sv
// Sends three captured ASCII digits as back-to-back 8N1 UART frames, hundreds first.
// Optional leading-zero suppression is enabled by defining ZERO_SUPPRESS_EN.
module ascii_uart_tx #(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [6:0] centenas_i,
    input  logic [6:0] decenas_i,
    input  logic [6:0] unidades_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned BaudW = $clog2(CLK_DIV);
    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q;
    logic [BaudW-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [1:0]       char_q;
    logic [6:0]       hund_q, tens_q, units_q;
    logic             tx_q, busy_q, done_q;

    logic             baud_wrap;
    logic [7:0]       cur_char;
    logic [1:0]       first_idx;

    always_comb begin
        baud_wrap = (baud_q == BaudMax);
        case (char_q)
            2'd0:    cur_char = {1'b0, hund_q};
            2'd1:    cur_char = {1'b0, tens_q};
            default: cur_char = {1'b0, units_q};
        endcase
`ifdef ZERO_SUPPRESS_EN
        // Skip leading ASCII '0' digits; the units digit is always sent.
        if (centenas_i != 7'h30) begin
            first_idx = 2'd0;
        end else if (decenas_i != 7'h30) begin
            first_idx = 2'd1;
        end else begin
            first_idx = 2'd2;
        end
`else
        first_idx = 2'd0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            char_q  <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            units_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle) begin
                baud_q <= baud_wrap ? '0 : baud_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    baud_q <= '0;
                    if (start_i) begin
                        hund_q  <= centenas_i;
                        tens_q  <= decenas_i;
                        units_q <= unidades_i;
                        char_q  <= first_idx;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_wrap) begin
                        bit_q   <= '0;
                        tx_q    <= cur_char[0];
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (baud_wrap) begin
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= cur_char[bit_q + 3'd1];
                        end
                    end
                end
                StStop: begin
                    if (baud_wrap) begin
                        if (char_q == 2'd2) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap.
                            char_q  <= char_q + 2'd1;
                            tx_q    <= 1'b0;
                            state_q <= StStart;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
